// File: rtl/nv_csa_accum_ctrl.sv
// nv_csa_accum_ctrl: packet-level multi-beat accumulator.
// Each accepted beat is folded into a carry-save sum/carry pair. A single
// carry-propagate add is done once per packet, in RESOLVE.
// Optional feature macro: NV_CSA_ACCUM_SAT_EN (saturate result to signed OUT_W).
module nv_csa_accum_ctrl #(
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned IN_W      = 8,
  parameter int unsigned ACC_W     = 20,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned CNT_W     = 5
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_IN*IN_W-1:0] in_data,
  input  logic                   in_last,
  input  logic                   acc_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic [CNT_W-1:0]       out_beats,
  output logic                   out_trunc,
  output logic                   out_sat
);

  typedef enum logic [1:0] {IDLE, ACC, RESOLVE, OUT} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   sum_q, carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               trunc_q;

  logic               accept;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               hit_max;
  logic [ACC_W-1:0]   tree_sum, tree_carry;
  logic [ACC_W-1:0]   res;
  logic [OUT_W-1:0]   res_red;
  logic               res_clip;

  // Beats are only taken in IDLE/ACC, and never while reset is asserted.
  assign in_ready = nvdla_core_rstn && ((state_q == IDLE) || (state_q == ACC));
  assign accept   = in_valid && in_ready;
  assign cnt_nxt  = (state_q == IDLE) ? CNT_W'(1) : cnt_q + CNT_W'(1);
  assign hit_max  = (cnt_nxt == CNT_W'(MAX_BEATS));

  // Carry-save tree: NUM_IN sign-extended operands plus the sum/carry feedback.
  always_comb begin
    logic [ACC_W-1:0] op_ext;
    logic [ACC_W-1:0] nsum;
    tree_sum   = (state_q == IDLE) ? '0 : sum_q;
    tree_carry = (state_q == IDLE) ? '0 : carry_q;
    op_ext     = '0;
    nsum       = '0;
    for (int k = 0; k < int'(NUM_IN); k++) begin
      op_ext     = ACC_W'(signed'(in_data[k*IN_W +: IN_W]));
      nsum       = tree_sum ^ tree_carry ^ op_ext;
      tree_carry = ((tree_sum & tree_carry) | (tree_sum & op_ext) |
                    (tree_carry & op_ext)) << 1;
      tree_sum   = nsum;
    end
  end

  // Final carry-propagate add and reduction to OUT_W.
  always_comb begin
    res      = sum_q + carry_q;
    res_red  = res[OUT_W-1:0];
    res_clip = 1'b0;
`ifdef NV_CSA_ACCUM_SAT_EN
    if (!((&res[ACC_W-1:OUT_W-1]) || !(|res[ACC_W-1:OUT_W-1]))) begin
      res_clip = 1'b1;
      res_red  = res[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                              : {1'b0, {(OUT_W-1){1'b1}}};
    end
`endif
  end

  // State register.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) state_q <= IDLE;
    else                  state_q <= state_d;
  end

  // Next-state logic; acc_clr overrides everything.
  always_comb begin
    state_d = state_q;
    if (acc_clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, ACC: if (accept) state_d = (in_last || hit_max) ? RESOLVE : ACC;
        RESOLVE:   state_d = OUT;
        OUT:       if (out_ready) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Accumulator, counter and result registers.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_trunc <= 1'b0;
      out_sat   <= 1'b0;
    end else if (acc_clr) begin
      sum_q     <= '0;
      carry_q   <= '0;
      cnt_q     <= '0;
      trunc_q   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACC: begin
          if (accept) begin
            sum_q   <= tree_sum;
            carry_q <= tree_carry;
            cnt_q   <= cnt_nxt;
            if (hit_max && !in_last) trunc_q <= 1'b1;
          end
        end
        RESOLVE: begin
          out_data  <= res_red;
          out_beats <= cnt_q;
          out_trunc <= trunc_q;
          out_sat   <= res_clip;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt_q     <= '0;
            trunc_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nv_csa_accum_ctrl.sv
// Testbench for nv_csa_accum_ctrl: table-driven packets plus handshake,
// abort and reset sequences. A second instance with OUT_W=12 covers clipping.
module tb_nv_csa_accum_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_last, acc_clr, out_ready;
  logic [31:0] in_data;

  logic        in_ready, out_valid, out_trunc, out_sat;
  logic [15:0] out_data;
  logic [4:0]  out_beats;

  logic        in_ready12, out_valid12, out_trunc12, out_sat12;
  logic [11:0] out_data12;
  logic [4:0]  out_beats12;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nv_csa_accum_ctrl dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .acc_clr(acc_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_trunc(out_trunc), .out_sat(out_sat)
  );

  nv_csa_accum_ctrl #(.OUT_W(12)) dut12 (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready12), .in_data(in_data),
    .in_last(in_last), .acc_clr(acc_clr),
    .out_valid(out_valid12), .out_ready(out_ready), .out_data(out_data12),
    .out_beats(out_beats12), .out_trunc(out_trunc12), .out_sat(out_sat12)
  );

  typedef struct {
    logic [31:0] data;
    int          beats;
    bit          last;
    logic [15:0] exp_data;
    logic [4:0]  exp_beats;
    bit          exp_trunc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a packet of identical beats; leaves the DUT in OUT with result checks done by caller.
  task automatic run_packet(input logic [31:0] data, input int beats, input bit last);
    for (int b = 0; b < beats; b++) begin
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last && (b == beats - 1);
      chk("in_ready_during_packet", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("resolve_out_valid", 32'(out_valid), 32'd0);
    chk("resolve_in_ready", 32'(in_ready), 32'd0);
    tick();
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    chk("out_in_ready", 32'(in_ready), 32'd0);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hs_out_valid", 32'(out_valid), 32'd0);
    chk("hs_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] hold_data;
    logic [4:0]  hold_beats;

    vecs[0] = '{32'h04030201, 1,  1'b1, 16'd10,   5'd1,  1'b0};
    vecs[1] = '{32'h80808080, 3,  1'b1, 16'hFA00, 5'd3,  1'b0};
    vecs[2] = '{32'h7F7F7F7F, 16, 1'b0, 16'd8128, 5'd16, 1'b1};
    vecs[3] = '{32'hFE02FF01, 5,  1'b1, 16'd0,    5'd5,  1'b0};
    vecs[4] = '{32'h00807F7F, 2,  1'b1, 16'h00FC, 5'd2,  1'b0};
    vecs[5] = '{32'hFFFFFFFF, 15, 1'b1, 16'hFFC4, 5'd15, 1'b0};
    vecs[6] = '{32'h01010101, 16, 1'b1, 16'h0040, 5'd16, 1'b0};

    rstn = 1'b0; in_valid = 1'b0; in_last = 1'b0; acc_clr = 1'b0;
    out_ready = 1'b0; in_data = '0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    #9 rstn = 1'b1;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    tick();

    // Table-driven packets
    for (int i = 0; i < 7; i++) begin
      run_packet(vecs[i].data, vecs[i].beats, vecs[i].last);
      chk($sformatf("v%0d_out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
      chk($sformatf("v%0d_out_beats", i), 32'(out_beats), 32'(vecs[i].exp_beats));
      chk($sformatf("v%0d_out_trunc", i), 32'(out_trunc), 32'(vecs[i].exp_trunc));
      chk($sformatf("v%0d_out_sat", i), 32'(out_sat), 32'd0);
      if (vecs[i].beats == 16 && !vecs[i].last) begin
`ifdef NV_CSA_ACCUM_SAT_EN
        chk("w12_out_data", 32'(out_data12), 32'h7FF);
        chk("w12_out_sat", 32'(out_sat12), 32'd1);
`else
        chk("w12_out_data", 32'(out_data12), 32'hFC0);
        chk("w12_out_sat", 32'(out_sat12), 32'd0);
`endif
        chk("w12_out_trunc", 32'(out_trunc12), 32'd1);
      end
      handshake();
    end

    // Backpressure: result held stable for 5 cycles
    run_packet(32'h04030201, 2, 1'b1);
    hold_data  = out_data;
    hold_beats = out_beats;
    chk("bp_first_data", 32'(hold_data), 32'd20);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_data_stable", 32'(out_data), 32'(hold_data));
      chk("bp_beats_stable", 32'(out_beats), 32'(hold_beats));
    end
    handshake();

    // Abort after 2 beats, with a beat presented alongside acc_clr
    in_valid = 1'b1; in_data = 32'h09090909;
    tick(); tick();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0; in_valid = 1'b0;
    chk("clr_in_ready", 32'(in_ready), 32'd1);
    chk("clr_out_valid", 32'(out_valid), 32'd0);
    run_packet(32'h00000005, 1, 1'b1);
    chk("clr_out_data", 32'(out_data), 32'd5);
    chk("clr_out_beats", 32'(out_beats), 32'd1);
    chk("clr_out_trunc", 32'(out_trunc), 32'd0);

    // Abort while a result is pending
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    chk("clr_out_discard_valid", 32'(out_valid), 32'd0);
    chk("clr_out_discard_ready", 32'(in_ready), 32'd1);

    // Reset pulsed mid-packet
    in_valid = 1'b1; in_data = 32'h09090909;
    tick(); tick();
    in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rstp_in_ready", 32'(in_ready), 32'd0);
    chk("rstp_out_valid", 32'(out_valid), 32'd0);
    chk("rstp_out_data", 32'(out_data), 32'd0);
    chk("rstp_out_beats", 32'(out_beats), 32'd0);
    chk("rstp_out_trunc", 32'(out_trunc), 32'd0);
    chk("rstp_out_sat", 32'(out_sat), 32'd0);
    #2 rstn = 1'b1;
    tick();
    run_packet(32'h00000005, 1, 1'b1);
    chk("rstp_result_data", 32'(out_data), 32'd5);
    chk("rstp_result_beats", 32'(out_beats), 32'd1);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
